// File: rtl/serial_cmp_driver.sv
// Transmit side of the bit-serial comparator link: latches an operand pair, shifts it out
// MSB-first on x/y with strobe a, then samples z. Optional capture: CMP_RESULT_CAPTURE_EN.
module serial_cmp_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  output logic             x,
  output logic             y,
  output logic             a,
  input  logic             z,
  output logic             done,
  output logic             result
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sx, sy;
  logic [CW-1:0]    cnt;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sx    <= '0;
      sy    <= '0;
      cnt   <= '0;
      x     <= 1'b0;
      y     <= 1'b0;
      a     <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x    <= 1'b0;
          y    <= 1'b0;
          a    <= 1'b0;
          done <= 1'b0;
          if (in_valid) begin
            sx    <= op_x;
            sy    <= op_y;
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // sx/sy are the sole bit source, so operand changes mid-frame are harmless
          x   <= sx[WIDTH-1];
          y   <= sy[WIDTH-1];
          a   <= 1'b1;
          sx  <= sx << 1;
          sy  <= sy << 1;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          x     <= 1'b0;
          y     <= 1'b0;
          a     <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMP_RESULT_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              result <= 1'b0;
    else if (state == DONE)  result <= z;
  end
`else
  logic unused_z;
  assign unused_z = z;
  assign result   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cmp_driver.sv
// Randomized scoreboard bench for serial_cmp_driver (WIDTH=4) plus a WIDTH=1 directed check.
module tb_serial_cmp_driver;
  localparam int W = 4;
`ifdef CMP_RESULT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] op_x = '0, op_y = '0;
  logic x, y, a, done, result;
  logic z = 1'b0;

  logic in_valid1 = 1'b0, ox1 = 1'b0, oy1 = 1'b0, z1 = 1'b1;
  logic in_ready1, x1, y1, a1, done1, result1;

  int checks = 0, errors = 0;
  int cyc = 0;
  int z_due_cyc = -1;
  logic z_due_val = 1'b0;
  int sent = 0, frames = 0;

  typedef struct { int ex; int ey; bit zv; int acc; } exp_t;
  exp_t sb[$];

  serial_cmp_driver #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_x(op_x), .op_y(op_y), .x(x), .y(y), .a(a), .z(z), .done(done), .result(result));

  serial_cmp_driver #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_x(ox1), .op_y(oy1), .x(x1), .y(y1), .a(a1), .z(z1), .done(done1), .result(result1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // z carries noise except on the one cycle the DUT is supposed to sample it
  always @(negedge clk) z = (cyc == z_due_cyc) ? z_due_val : 1'($urandom);

  // Monitor: rebuild each frame from the strobed bits and compare against the scoreboard
  int nbits = 0, first_cyc = 0, cx = 0, cy = 0;
  bit exp_result = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      nbits = 0; cx = 0; cy = 0; exp_result = 1'b0;
    end else begin
      if (a) begin
        if (nbits == 0) first_cyc = cyc;
        cx = (cx << 1) | int'(x);
        cy = (cy << 1) | int'(y);
        nbits++;
        check("ready_low_while_busy", int'(in_ready), 0);
      end
      if (done) begin
        check("a_done_exclusive", int'(a), 0);
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("x_bits", cx, e.ex);
          check("y_bits", cy, e.ey);
          check("strobe_count", nbits, W);
          check("first_bit_latency", first_cyc - e.acc, 1);
          check("done_latency", cyc - e.acc, W + 1);
          exp_result = CAP ? e.zv : 1'b0;
        end
        nbits = 0; cx = 0; cy = 0;
        frames++;
      end
      check("result", int'(result), int'(exp_result));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns after the acceptance edge with in_valid dropped
  task automatic send(input logic [W-1:0] vx, input logic [W-1:0] vy, input bit zv, output int acc);
    exp_t e;
    int n = 0;
    acc = -1;
    op_x = vx; op_y = vy; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    e.ex = int'(vx); e.ey = int'(vy); e.zv = zv; e.acc = acc;
    sb.push_back(e);
    z_due_cyc = acc + W; z_due_val = zv;
    sent++;
    @(negedge clk);
    in_valid = 1'b0;
    op_x = W'($urandom); op_y = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int acc1, acc2, seen, n;
    #20 rst_n = 1'b1;
    idle(1);
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", int'({x, y, a, done}), 0);
      check("idle_ready", int'(in_ready), 1);
    end

    send(4'b1010, 4'b0110, 1'b1, acc1);
    idle(W + 3);
    send(4'b1010, 4'b0110, 1'b0, acc1);
    idle(W + 3);

    // second request held while the first frame is still shifting
    send(W'($urandom), W'($urandom), 1'b1, acc1);
    send(4'hF, 4'h0, 1'b0, acc2);
    check("b2b_accept_gap", acc2 - acc1, W + 2);

    repeat (40) begin
      send(W'($urandom), W'($urandom), 1'($urandom), acc1);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 4));
    end
    drain();
    idle(2);
    check("frames_done", frames, sent);

    // reset mid-frame abandons it
    send(4'hC, 4'h3, 1'b1, acc1);
    seen = 0; n = 0;
    while (seen < 2 && n < 30) begin
      @(negedge clk);
      if (a) seen++;
      n++;
    end
    check("reset_two_bits_seen", seen, 2);
    #2 rst_n = 1'b0;
    #1 check("async_a_drop", int'(a), 0);
    check("async_x_drop", int'(x), 0);
    sb.delete();
    z_due_cyc = -1;
    repeat (3) begin @(negedge clk); check("no_done_in_reset", int'(done), 0); end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_quiet", int'({a, done}), 0);
      check("post_reset_ready", int'(in_ready), 1);
    end

    send(W'($urandom), W'($urandom), 1'b1, acc1);
    drain();
    idle(2);

    // WIDTH=1 instance
    ox1 = 1'b1; oy1 = 1'b0; in_valid1 = 1'b1;
    check("w1_ready", int'(in_ready1), 1);
    @(negedge clk); in_valid1 = 1'b0;
    @(negedge clk);
    check("w1_strobe", int'({a1, x1, y1, done1}), 4'b1100);
    @(negedge clk);
    check("w1_done", int'({a1, done1}), 2'b01);
    check("w1_result", int'(result1), int'(CAP));
    @(negedge clk);
    check("w1_done_pulse_end", int'(done1), 0);
    check("w1_ready_again", int'(in_ready1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
